// File: rtl/key_debouncer.sv
// Per-key 2-FF synchronizer, polarity normalisation and stable-time debounce with press pulse.
// Optional KEY_RELEASE_PULSE_EN adds a registered one-cycle key_release pulse per key.
module key_debouncer #(
   parameter int NUM_KEYS      = 4,
   parameter int DB_CYCLES     = 1_000_000,
   parameter int ACTIVE_LOW_IN = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] key_raw,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] key_press,
   output logic                key_any
`ifdef KEY_RELEASE_PULSE_EN
   ,
   output logic [NUM_KEYS-1:0] key_release
`endif
);

   localparam int                 CW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0]      CNT_MAX  = CW'(DB_CYCLES - 1);
   localparam logic [NUM_KEYS-1:0] RAW_IDLE = (ACTIVE_LOW_IN != 0) ? '1 : '0;

   logic [NUM_KEYS-1:0] s1_q, s1_d;
   logic [NUM_KEYS-1:0] s2_q, s2_d;
   logic [NUM_KEYS-1:0] level_q, level_d;
   logic [NUM_KEYS-1:0] press_q, press_d;
   logic [CW-1:0]       cnt_q [NUM_KEYS];
   logic [CW-1:0]       cnt_d [NUM_KEYS];
   logic [NUM_KEYS-1:0] pressed;
`ifdef KEY_RELEASE_PULSE_EN
   logic [NUM_KEYS-1:0] release_q, release_d;
`endif

   // Normalised synchronized input: 1 means the key is held down.
   assign pressed = (ACTIVE_LOW_IN != 0) ? ~s2_q : s2_q;

   always_comb begin
      s1_d    = key_raw;
      s2_d    = s1_q;
      level_d = level_q;
      press_d = '0;
`ifdef KEY_RELEASE_PULSE_EN
      release_d = '0;
`endif
      for (int k = 0; k < NUM_KEYS; k++) begin
         cnt_d[k] = '0;
         if (pressed[k] != level_q[k]) begin
            if (cnt_q[k] == CNT_MAX) begin
               level_d[k] = pressed[k];
               press_d[k] = pressed[k];
`ifdef KEY_RELEASE_PULSE_EN
               release_d[k] = ~pressed[k];
`endif
            end else begin
               cnt_d[k] = cnt_q[k] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_q    <= RAW_IDLE;
         s2_q    <= RAW_IDLE;
         level_q <= '0;
         press_q <= '0;
`ifdef KEY_RELEASE_PULSE_EN
         release_q <= '0;
`endif
         for (int k = 0; k < NUM_KEYS; k++) cnt_q[k] <= '0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         level_q <= level_d;
         press_q <= press_d;
`ifdef KEY_RELEASE_PULSE_EN
         release_q <= release_d;
`endif
         for (int k = 0; k < NUM_KEYS; k++) cnt_q[k] <= cnt_d[k];
      end
   end

   assign key_level = level_q;
   assign key_press = press_q;
   assign key_any   = |level_q;
`ifdef KEY_RELEASE_PULSE_EN
   assign key_release = release_q;
`endif

endmodule
